// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with parity/stop checking and a valid/ready output
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   uart_rx     serial line, idle high, asynchronous to clk
//   rx_data     received word, LSB first on the wire
//   rx_valid    rx_data and flags valid, held until rx_valid & rx_ready
//   rx_ready    consumer accepts the held word
//   parity_err  parity mismatch for the held word
//   frame_err   a stop bit was sampled low for the held word
//   overrun     sticky, a frame was dropped while a word was held
//   busy        receiver FSM not idle
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state;
    logic                 rx_m, rx_s, armed, par_bad, stop_bad;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick, fire, accept, frame_bad;
    assign tick      = cnt == LAST;
    // fire marks the cycle of the final stop sample; delivery lands on the following edge
    assign fire      = state == STOP && tick && bit_cnt == BW'(STOP_BITS - 1);
    assign accept    = rx_valid && rx_ready;
    assign frame_bad = stop_bad || !rx_s;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            armed      <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m  <= uart_rx;
            rx_s  <= rx_m;
            // a framing error disarms the receiver so a break is not decoded as a stream of frames
            armed <= (fire && frame_bad) ? 1'b0 : (armed || rx_s);
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_cnt  <= '0;
                    par_bad  <= 1'b0;
                    stop_bad <= 1'b0;
                    if (armed && !rx_s) state <= START;
                end
                START: begin
                    cnt <= (cnt == MID) ? '0 : cnt + 1'b1;
                    if (cnt == MID) state <= rx_s ? IDLE : DATA;
                end
                DATA: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        par_bad <= (^shift ^ rx_s) != (PARITY_ODD != 0);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        stop_bad <= frame_bad;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (fire) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // a word accepted on the delivery cycle frees the slot for the new one
            if (fire && (!rx_valid || accept)) begin
                rx_data    <= shift;
                parity_err <= par_bad;
                frame_err  <= frame_bad;
                rx_valid   <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            overrun <= accept ? 1'b0 : ((fire && rx_valid) ? 1'b1 : overrun);
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench for uart_rx_frame in 8N1, even-parity and two-stop-bit builds
module tb_uart_rx_frame;
    localparam int CPB = 16;
    localparam int HALF = CPB / 2;
    typedef struct packed {logic [7:0] d; logic p; logic f;} exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxl[3] = '{1'b1, 1'b1, 1'b1};
    logic       rdy[3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] dat[3];
    logic       vld[3], pe[3], fe[3], ov[3], bsy[3];
    logic       pv[3];
    int         vcount[3] = '{0, 0, 0};
    int         checks = 0;
    int         errors = 0;
    exp_t       q[3][$];
    exp_t       mon_e;

    always #5 clk = ~clk;

    uart_rx_frame #(.CLKS_PER_BIT(CPB)) d0 (
        .clk(clk), .rst(rst), .uart_rx(rxl[0]), .rx_data(dat[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bsy[0]));
    uart_rx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) d1 (
        .clk(clk), .rst(rst), .uart_rx(rxl[1]), .rx_data(dat[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bsy[1]));
    uart_rx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) d2 (
        .clk(clk), .rst(rst), .uart_rx(rxl[2]), .rx_data(dat[2]), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bsy[2]));

    // each new word (rising rx_valid) is compared against the oldest expectation for that receiver
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) vcount[i]++;
            if (vld[i] && !pv[i]) begin
                checks++;
                if (q[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word dut%0d: got data=%h pe=%b fe=%b, required no word", i, dat[i], pe[i], fe[i]);
                end else begin
                    mon_e = q[i].pop_front();
                    if ({dat[i], pe[i], fe[i]} !== mon_e) begin
                        errors++;
                        $display("FAIL word dut%0d: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                                 i, dat[i], pe[i], fe[i], mon_e.d, mon_e.p, mon_e.f);
                    end
                end
            end
            pv[i] = vld[i];
        end
    end

    task automatic bit_out(input int i, input logic b);
        rxl[i] = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic idle(input int i, input int n);
        for (int k = 0; k < n; k++) bit_out(i, 1'b1);
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit np, input logic pb, input int ns, input logic [1:0] sv);
        bit_out(i, 1'b0);
        for (int k = 0; k < 8; k++) bit_out(i, d[k]);
        if (np) bit_out(i, pb);
        for (int k = 0; k < ns; k++) bit_out(i, sv[k]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dat[i], vld[i], pe[i], fe[i], ov[i], bsy[i]} !== 13'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h, required 0", i, {dat[i], vld[i], pe[i], fe[i], ov[i], bsy[i]});
            end
        end
        @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic;
        vcount[0] = 0;
        q[0].push_back({8'hA5, 2'b00});
        send(0, 8'hA5, 0, 1'b0, 1, 2'b11);
        idle(0, 2);
        @(negedge clk);
        checks++;
        if (vcount[0] !== 1) begin errors++; $display("FAIL basic_pulse: got %0d valid cycles, required 1", vcount[0]); end
        checks++;
        if (ov[0] !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b, required 0", ov[0]); end
        checks++;
        if (q[0].size() != 0) begin errors++; $display("FAIL basic_pending: got %0d words missing, required 0", q[0].size()); end
    endtask

    task automatic test_glitch;
        logic seen = 1'b0;
        vcount[0] = 0;
        @(posedge clk);
        rxl[0] = 1'b0;
        repeat (4) @(posedge clk);
        rxl[0] = 1'b1;
        for (int k = 0; k < HALF + 3; k++) begin
            @(negedge clk);
            if (bsy[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy never high, required busy during start"); end
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b, required 0", bsy[0]); end
        idle(0, 2);
        checks++;
        if (vcount[0] !== 0) begin errors++; $display("FAIL glitch_output: got %0d valid cycles, required 0", vcount[0]); end
    endtask

    task automatic test_parity;
        q[1].push_back({8'h07, 2'b00});
        send(1, 8'h07, 1, 1'b1, 1, 2'b11);
        idle(1, 2);
        q[1].push_back({8'h07, 2'b10});
        send(1, 8'h07, 1, 1'b0, 1, 2'b11);
        idle(1, 2);
        checks++;
        if (q[1].size() != 0) begin errors++; $display("FAIL parity_pending: got %0d words missing, required 0", q[1].size()); end
    endtask

    task automatic test_break;
        vcount[2] = 0;
        q[2].push_back({8'h3C, 2'b01});
        send(2, 8'h3C, 0, 1'b0, 2, 2'b01);
        repeat (40 * CPB) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vcount[2] !== 1) begin errors++; $display("FAIL break_words: got %0d valid cycles, required 1", vcount[2]); end
        checks++;
        if (bsy[2] !== 1'b0) begin errors++; $display("FAIL break_busy: got %b, required 0", bsy[2]); end
        checks++;
        if ({dat[2], fe[2]} !== {8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL break_held: got data=%h fe=%b, required data=3c fe=1", dat[2], fe[2]);
        end
        idle(2, 2);
        q[2].push_back({8'h11, 2'b00});
        send(2, 8'h11, 0, 1'b0, 2, 2'b11);
        idle(2, 1);
        checks++;
        if (q[2].size() != 0) begin errors++; $display("FAIL break_pending: got %0d words missing, required 0", q[2].size()); end
    endtask

    task automatic test_overrun;
        rdy[0] = 1'b0;
        q[0].push_back({8'h12, 2'b00});
        send(0, 8'h12, 0, 1'b0, 1, 2'b11);
        idle(0, 1);
        send(0, 8'h34, 0, 1'b0, 1, 2'b11);
        idle(0, 1);
        @(negedge clk);
        checks++;
        if ({dat[0], vld[0], ov[0]} !== {8'h12, 2'b11}) begin
            errors++;
            $display("FAIL overrun_hold: got data=%h valid=%b ov=%b, required data=12 valid=1 ov=1", dat[0], vld[0], ov[0]);
        end
        @(posedge clk);
        rdy[0] = 1'b1;
        @(posedge clk);
        rdy[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({vld[0], ov[0]} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_accept: got valid=%b ov=%b, required valid=0 ov=0", vld[0], ov[0]);
        end
        rdy[0] = 1'b1;
        q[0].push_back({8'h56, 2'b00});
        send(0, 8'h56, 0, 1'b0, 1, 2'b11);
        idle(0, 1);
        checks++;
        if (q[0].size() != 0) begin errors++; $display("FAIL overrun_pending: got %0d words missing, required 0", q[0].size()); end
    endtask

    task automatic test_reset_mid;
        bit_out(0, 1'b0);
        bit_out(0, 1'b1);
        bit_out(0, 1'b0);
        bit_out(0, 1'b0);
        rst = 1'b1;
        rxl[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bsy[0], vld[0]} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b valid=%b, required 0 0", bsy[0], vld[0]);
        end
        rst = 1'b0;
        idle(0, 2);
        q[0].push_back({8'h42, 2'b00});
        send(0, 8'h42, 0, 1'b0, 1, 2'b11);
        idle(0, 1);
        @(negedge clk);
        checks++;
        if (q[0].size() != 0 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d words missing ov=%b, required 0 ov=0", q[0].size(), ov[0]);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_parity;
        test_break;
        test_overrun;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART receiver and the next generation of the board's fixed 8N1 receive path.
- Function: synchronises the asynchronous rx line, validates the start bit at mid-bit, and shifts in DATA_BITS bits LSB-first.
- Checks optional parity and 1 or 2 stop bits.
- Delivers each word with error flags over a valid/ready handshake to downstream logic (LED/debug, command parser).

Parameters:
- CLKS_PER_BIT, 234, clock cycles per bit period (>= 4).
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_EN, 0, 1 = parity bit present after data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN = 0).
- STOP_BITS, 1, number of stop bits checked (1 or 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  received word.
- rx_valid  output  1  rx_data and flags valid.
- rx_ready  input  1  consumer accepts the word.
- parity_err  output  1  parity mismatch for the held word.
- frame_err  output  1  a stop bit sampled low for the held word.
- overrun  output  1  sticky; a frame was dropped because rx_valid was still high.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; counters 0; synchroniser flops preset to 1.
  - Reset asserted mid-frame aborts the frame; nothing is delivered.
- Input path: 2-flop synchroniser on uart_rx. All decisions use the synchronised bit rx_s (2 cycles of input latency).
- Counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - An armed FSM with rx_s = 0 goes to START and clears the counter.
  - Armed means rx_s has been seen high since the last frame_err. After a framing error, a line held low (break) is ignored until it returns high.
- START:
  - Count to HALF-1 and sample rx_s.
  - rx_s = 1 is a glitch: return to IDLE, no output, no flags.
  - rx_s = 0: go to DATA with the counter cleared.
- DATA:
  - Sample every CLKS_PER_BIT cycles (mid-bit); shift right into the shift register, so the first bit lands in the LSB.
  - After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - One sample after CLKS_PER_BIT cycles.
  - Error if (XOR of data bits ^ sampled bit) != PARITY_ODD.
- STOP:
  - STOP_BITS samples, each CLKS_PER_BIT apart. Any sample = 0 sets the frame error.
  - The frame completes on the cycle of the last stop sample; the FSM returns to IDLE on the next cycle.
- Delivery, on the cycle after the last stop sample:
  - If rx_valid = 0: load rx_data, parity_err, frame_err and set rx_valid = 1.
  - If rx_valid = 1: discard the new frame, keep the held word and flags unchanged, set overrun = 1.
- Handshake:
  - rx_valid holds, with rx_data and flags stable, until a cycle with rx_valid & rx_ready. rx_valid drops on the next edge.
  - Delivery and acceptance in the same cycle: the new word is loaded and rx_valid stays 1 (no overrun).
  - rx_ready while rx_valid = 0 is ignored.
- Overrun clears on the first accepted transfer after it was set.
- Reception continues in every state regardless of rx_ready.
- busy = (state != IDLE).
- End-to-end latency: rx_valid rises 1 cycle after the final stop sample, which is about 2 + HALF + (1+DATA_BITS+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT cycles after the falling edge on uart_rx.

Test Plan:
- 8N1, CLKS_PER_BIT=16: send 0xA5, rx_ready held 1 -> rx_valid pulses 1 cycle, rx_data=0xA5, parity_err=0, frame_err=0, overrun=0.
- Glitch: uart_rx low for 4 cycles, then high -> START aborts at mid-bit, no rx_valid, busy returns to 0 within HALF+3 cycles.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> rx_data=0x07, parity_err=0. Same word with parity bit 0 -> parity_err=1.
- STOP_BITS=2: send 0x3C with the second stop bit low, then hold the line low for 40 bit times -> frame_err=1 with rx_data=0x3C. No new frame until the line goes high, then 0x11 is received cleanly.
- rx_ready=0: send 0x12 then 0x34 -> rx_data stays 0x12, overrun=1. Raise rx_ready 1 cycle -> rx_valid=0, overrun=0. Then send 0x56 -> received normally.
- Assert rst mid-DATA of 0x99, release, send 0x42 -> no output for 0x99, rx_data=0x42 with all flags 0.
